// File: rtl/gpi_debounce.sv
// -----------------------------------------------------------------------------
// gpi_debounce
//
// Input conditioning for the general-purpose input port. Each pad bit is
// brought into the clk_sys_i domain through its own synchroniser chain and
// then debounced by an independent stability counter. A new level is only
// accepted once the synchronised input has disagreed with the current output
// for DebounceCycles consecutive clock edges. Accepted changes produce
// single-cycle rise/fall pulses and a combined changed flag.
//
// Parameters:
//   GpiWidth       - number of input bits
//   SyncStages     - flops per synchroniser chain (2..4)
//   DebounceCycles - consecutive mismatching edges needed to accept a level (>= 1)
//   ResetValue     - reset level of the synchronisers and of gp_o
//
// Ports:
//   clk_sys_i   in   1         system clock
//   rst_sys_ni  in   1         asynchronous active-low reset
//   raw_i       in   GpiWidth  asynchronous pad inputs
//   gp_o        out  GpiWidth  debounced levels
//   rise_o      out  GpiWidth  one-cycle pulse when gp_o[b] goes 0->1
//   fall_o      out  GpiWidth  one-cycle pulse when gp_o[b] goes 1->0
//   changed_o   out  1         OR of all rise/fall pulses, same cycle
//
// All outputs come straight from flops; raw_i only feeds the first
// synchroniser stage.
// -----------------------------------------------------------------------------
module gpi_debounce #(
  parameter int unsigned         GpiWidth       = 8,
  parameter int unsigned         SyncStages     = 2,
  parameter int unsigned         DebounceCycles = 500_000,
  parameter logic [GpiWidth-1:0] ResetValue     = '0
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  input  logic [GpiWidth-1:0] raw_i,
  output logic [GpiWidth-1:0] gp_o,
  output logic [GpiWidth-1:0] rise_o,
  output logic [GpiWidth-1:0] fall_o,
  output logic                changed_o
);

  // Counter only has to reach DebounceCycles-1; keep at least one bit so the
  // DebounceCycles == 1 case still has a legal (always-zero) counter.
  localparam int unsigned CntWidth =
    ($clog2(DebounceCycles) > 1) ? $clog2(DebounceCycles) : 1;

  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] CntZero = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  // Per-bit debounce state. STABLE: output agrees with the synchronised
  // input and the counter is zero. PENDING: a mismatch is being timed.
  typedef enum logic [0:0] {
    StStable  = 1'b0,
    StPending = 1'b1
  } deb_state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser chains
  // ---------------------------------------------------------------------------
  logic [GpiWidth-1:0] sync_chain_q [SyncStages];
  logic [GpiWidth-1:0] sync_q;

  // Shift raw pad levels through the synchroniser chain.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int i = 0; i < int'(SyncStages); i++) begin
        sync_chain_q[i] <= ResetValue;
      end
    end else begin
      sync_chain_q[0] <= raw_i;
      for (int i = 1; i < int'(SyncStages); i++) begin
        sync_chain_q[i] <= sync_chain_q[i-1];
      end
    end
  end

  assign sync_q = sync_chain_q[SyncStages-1];

  // ---------------------------------------------------------------------------
  // Debounce state, counters and output registers
  // ---------------------------------------------------------------------------
  deb_state_e          state_q [GpiWidth];
  deb_state_e          state_d [GpiWidth];
  logic [CntWidth-1:0] cnt_q   [GpiWidth];
  logic [CntWidth-1:0] cnt_d   [GpiWidth];

  logic [GpiWidth-1:0] gp_q,   gp_d;
  logic [GpiWidth-1:0] rise_q, rise_d;
  logic [GpiWidth-1:0] fall_q, fall_d;
  logic                changed_q, changed_d;

  logic [GpiWidth-1:0] mismatch;

  assign mismatch = sync_q ^ gp_q;

  // Per-bit next-state: time mismatches, reject glitches, accept stable levels.
  always_comb begin
    gp_d   = gp_q;
    rise_d = {GpiWidth{1'b0}};
    fall_d = {GpiWidth{1'b0}};

    for (int b = 0; b < int'(GpiWidth); b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = cnt_q[b];

      case (state_q[b])
        StStable: begin
          if (!mismatch[b]) begin
            state_d[b] = StStable;
            cnt_d[b]   = CntZero;
          end else if (CntMax == CntZero) begin
            // Single-cycle debounce: accept on the first mismatching edge.
            state_d[b] = StStable;
            cnt_d[b]   = CntZero;
            gp_d[b]    = sync_q[b];
            rise_d[b]  = sync_q[b];
            fall_d[b]  = ~sync_q[b];
          end else begin
            // Counter is zero in STABLE, so this is the first counted edge.
            state_d[b] = StPending;
            cnt_d[b]   = CntOne;
          end
        end

        StPending: begin
          if (!mismatch[b]) begin
            // Input returned to the old level before acceptance: drop it.
            state_d[b] = StStable;
            cnt_d[b]   = CntZero;
          end else if (cnt_q[b] == CntMax) begin
            state_d[b] = StStable;
            cnt_d[b]   = CntZero;
            gp_d[b]    = sync_q[b];
            rise_d[b]  = sync_q[b];
            fall_d[b]  = ~sync_q[b];
          end else begin
            state_d[b] = StPending;
            cnt_d[b]   = cnt_q[b] + CntOne;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean STABLE state.
          state_d[b] = StStable;
          cnt_d[b]   = CntZero;
        end
      endcase
    end

    changed_d = |(rise_d | fall_d);
  end

  // Register per-bit debounce state and counters.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int b = 0; b < int'(GpiWidth); b++) begin
        state_q[b] <= StStable;
        cnt_q[b]   <= CntZero;
      end
    end else begin
      for (int b = 0; b < int'(GpiWidth); b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  // Register the debounced level and the edge pulses.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gp_q      <= ResetValue;
      rise_q    <= {GpiWidth{1'b0}};
      fall_q    <= {GpiWidth{1'b0}};
      changed_q <= 1'b0;
    end else begin
      gp_q      <= gp_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign gp_o      = gp_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// -----------------------------------------------------------------------------
// tb_gpi_debounce
//
// Scoreboard bench for gpi_debounce (GpiWidth=8, SyncStages=2,
// DebounceCycles=4, ResetValue=0). Each driven cycle pushes the expected
// outputs for the following clock edge; the outputs are sampled on the
// falling edge and compared against the popped entry.
//
// Expected model: the synchronised value seen after edge k is the raw value
// driven before edge k-1. A bit of gp_o flips at edge k when the four
// synchronised samples from edges k-4..k-1 all disagree with its current
// level.
// -----------------------------------------------------------------------------
module tb_gpi_debounce;

  logic       clk_sys_i;
  logic       rst_sys_ni;
  logic [7:0] raw_i;
  logic [7:0] gp_o;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       changed_o;

  gpi_debounce #(
    .GpiWidth      (8),
    .SyncStages    (2),
    .DebounceCycles(4),
    .ResetValue    (8'h00)
  ) dut (
    .clk_sys_i (clk_sys_i),
    .rst_sys_ni(rst_sys_ni),
    .raw_i     (raw_i),
    .gp_o      (gp_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .changed_o (changed_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct packed {
    logic [7:0] gp;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       changed;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sync_hist[$];
  logic [7:0] raw_prev;
  logic [7:0] gp_m;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt;
  int fall_cnt;
  int chg_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    sync_hist.delete();
    for (int i = 0; i < 4; i++) sync_hist.push_back(8'h00);
    raw_prev = 8'h00;
    gp_m     = 8'h00;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    fall_cnt = 0;
    chg_cnt  = 0;
  endtask

  // Drive one cycle of stimulus, predict the next edge, then check it.
  task automatic step(input logic [7:0] raw);
    logic [7:0] all_diff;
    logic [7:0] gp_new;
    exp_t       e;
    raw_i    = raw;
    all_diff = 8'hFF;
    for (int i = 0; i < 4; i++) all_diff = all_diff & (sync_hist[i] ^ gp_m);
    gp_new    = gp_m ^ all_diff;
    e.gp      = gp_new;
    e.rise    = gp_new & ~gp_m;
    e.fall    = ~gp_new & gp_m;
    e.changed = |(e.rise | e.fall);
    exp_q.push_back(e);
    void'(sync_hist.pop_front());
    sync_hist.push_back(raw_prev);
    raw_prev = raw;
    gp_m     = gp_new;

    @(posedge clk_sys_i);
    @(negedge clk_sys_i);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("gp_o",      32'(gp_o),      32'(e.gp));
      check_eq("rise_o",    32'(rise_o),    32'(e.rise));
      check_eq("fall_o",    32'(fall_o),    32'(e.fall));
      check_eq("changed_o", 32'(changed_o), 32'(e.changed));
    end
    rise_cnt += $countones(rise_o);
    fall_cnt += $countones(fall_o);
    chg_cnt  += int'(changed_o);
  endtask

  // Assert reset asynchronously, check reset values, release on a falling edge.
  task automatic apply_reset(input logic [7:0] raw);
    raw_i      = raw;
    rst_sys_ni = 1'b0;
    #1;
    check_eq("rst_async_gp", 32'(gp_o), 32'h00);
    repeat (3) @(negedge clk_sys_i);
    check_eq("rst_gp",      32'(gp_o),      32'h00);
    check_eq("rst_rise",    32'(rise_o),    32'h00);
    check_eq("rst_fall",    32'(fall_o),    32'h00);
    check_eq("rst_changed", 32'(changed_o), 32'h0);
    model_reset();
    rst_sys_ni = 1'b1;
  endtask

  initial begin
    rst_sys_ni = 1'b1;
    raw_i      = 8'h00;
    model_reset();
    #3;

    // Reset with all inputs high, then let them through.
    apply_reset(8'hFF);
    clear_counts();
    for (int i = 0; i < 8; i++) step(8'hFF);
    check_eq("reset_release_rises",   32'(rise_cnt), 32'd8);
    check_eq("reset_release_changed", 32'(chg_cnt),  32'd1);
    check_eq("reset_release_gp",      32'(gp_o),     32'hFF);

    // All inputs back low.
    clear_counts();
    for (int i = 0; i < 8; i++) step(8'h00);
    check_eq("all_fall_count", 32'(fall_cnt), 32'd8);
    check_eq("all_fall_gp",    32'(gp_o),     32'h00);

    // Clean edge on bit 0.
    clear_counts();
    for (int i = 0; i < 8; i++) step(8'h01);
    check_eq("clean_rises", 32'(rise_cnt), 32'd1);
    check_eq("clean_falls", 32'(fall_cnt), 32'd0);

    // Three-cycle glitch on bit 3.
    clear_counts();
    for (int i = 0; i < 3; i++) step(8'h09);
    for (int i = 0; i < 8; i++) step(8'h01);
    check_eq("glitch_pulses", 32'(rise_cnt + fall_cnt), 32'd0);
    check_eq("glitch_gp",     32'(gp_o),                32'h01);

    // Bounce on bit 2, settling high.
    clear_counts();
    step(8'h05); step(8'h01); step(8'h05); step(8'h01); step(8'h05);
    for (int i = 0; i < 8; i++) step(8'h05);
    check_eq("bounce_rises", 32'(rise_cnt), 32'd1);
    check_eq("bounce_gp",    32'(gp_o),     32'h05);

    // Bit 1 clean rise alongside a two-cycle glitch on bit 7.
    clear_counts();
    step(8'h87); step(8'h87);
    for (int i = 0; i < 8; i++) step(8'h07);
    check_eq("simul_rises",   32'(rise_cnt), 32'd1);
    check_eq("simul_changed", 32'(chg_cnt),  32'd1);
    check_eq("simul_gp",      32'(gp_o),     32'h07);

    // Reset while bit 4 is pending; release with the inputs still high.
    for (int i = 0; i < 3; i++) step(8'h17);
    #2;
    apply_reset(8'h17);
    clear_counts();
    for (int i = 0; i < 8; i++) step(8'h17);
    check_eq("midrst_rises",   32'(rise_cnt), 32'd4);
    check_eq("midrst_changed", 32'(chg_cnt),  32'd1);
    check_eq("midrst_gp",      32'(gp_o),     32'h17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
